// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - shared SIMD lane bus defaults and width helpers
package simd_pkg;

  localparam int DEFAULT_LANES = 8;
  localparam int DEFAULT_WIDTH = 8;

  // ceil(log2(n)), but never less than 1 so index ports always have a bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/simd_lane_serializer.sv
// rtl/simd_lane_serializer.sv - packed lane vector to one-lane-per-beat stream with running sum
module simd_lane_serializer
  import simd_pkg::*;
#(
  parameter int LANES = DEFAULT_LANES,
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int IDX_W = clog2_min1(LANES),
  localparam int SUM_W = WIDTH + IDX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_lane,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_last,
  output logic [SUM_W-1:0]       out_sum
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state_q, state_d;
  logic [LANES*WIDTH-1:0] vec_q;
  logic [IDX_W-1:0]       idx_q;
  logic [SUM_W-1:0]       acc_q;
  logic                   capture;
  logic                   beat;

  // Output view of the registered state; lane data is forced to zero outside SHIFT
  always_comb begin
    out_valid = (state_q == SHIFT);
    out_idx   = idx_q;
    out_last  = (state_q == SHIFT) && (idx_q == IDX_W'(LANES - 1));
    out_lane  = '0;
    if (state_q == SHIFT) out_lane = vec_q[int'(idx_q)*WIDTH +: WIDTH];
    out_sum   = acc_q + SUM_W'(out_lane);
    // Ready on the last transferring beat so a new vector follows with no bubble
    in_ready  = !rst && ((state_q == IDLE) || (out_last && out_ready));
    capture   = in_valid && in_ready;
    beat      = out_valid && out_ready;
  end

  // Next-state: leave SHIFT only when the last beat goes out with nothing queued behind it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture) state_d = SHIFT;
      SHIFT:   if (beat && out_last && !capture) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Vector capture, lane index advance and running-sum accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q <= '0;
      idx_q <= '0;
      acc_q <= '0;
    end else if (capture) begin
      vec_q <= in_data;
      idx_q <= '0;
      acc_q <= '0;
    end else if (beat) begin
      if (out_last) begin
        idx_q <= '0;
        acc_q <= '0;
      end else begin
        idx_q <= idx_q + IDX_W'(1);
        acc_q <= out_sum;
      end
    end
  end

endmodule
